// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, write port, PC controls and sweep status.
interface regfile_mp_if #(
  parameter int DAT_WIDTH = 64,
  parameter int REG_COUNT = 32,
  parameter int RD_PORTS  = 2
);
  localparam int ID_W = $clog2(REG_COUNT);

  logic [RD_PORTS-1:0]           rd_en_i;
  logic [RD_PORTS*ID_W-1:0]      rd_id_i;
  logic [RD_PORTS*DAT_WIDTH-1:0] rd_dat_o;
  logic                          wr_en_i;
  logic [ID_W-1:0]               wr_id_i;
  logic [DAT_WIDTH-1:0]          wr_dat_i;
  logic                          pc_we_i;
  logic [DAT_WIDTH-1:0]          pc_dat_i;
  logic                          pc_inc_i;
  logic [DAT_WIDTH-1:0]          pc_o;
  logic                          busy_o;

  modport master (
    output rd_en_i, rd_id_i, wr_en_i, wr_id_i, wr_dat_i,
           pc_we_i, pc_dat_i, pc_inc_i,
    input  rd_dat_o, pc_o, busy_o
  );

  modport slave (
    input  rd_en_i, rd_id_i, wr_en_i, wr_id_i, wr_dat_i,
           pc_we_i, pc_dat_i, pc_inc_i,
    output rd_dat_o, pc_o, busy_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with dedicated PC, zero register and reset clear sweep.
// Define REGFILE_BYPASS_EN for write-first reads; default build is read-first.
module regfile_mp_rd_port #(
  parameter int DAT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DAT_WIDTH-1:0] val,
  output logic [DAT_WIDTH-1:0] dat
);
  always_ff @(posedge clk) begin
    if (rst)     dat <= '0;
    else if (en) dat <= clr ? '0 : val;
  end
endmodule

module regfile_mp #(
  parameter int                   DAT_WIDTH = 64,
  parameter int                   REG_COUNT = 32,
  parameter int                   RD_PORTS  = 2,
  parameter int                   PC_INDEX  = REG_COUNT - 1,
  parameter logic [DAT_WIDTH-1:0] PC_RESET  = DAT_WIDTH'(64'h800000000000)
) (
  input logic         clk_i,
  input logic         rst_i,
  regfile_mp_if.slave bus
);
  localparam int                   ID_W    = $clog2(REG_COUNT);
  localparam logic [ID_W-1:0]      PC_ID   = ID_W'(PC_INDEX);
  localparam logic [ID_W-1:0]      LAST_ID = ID_W'(REG_COUNT - 1);
  localparam logic [DAT_WIDTH-1:0] PC_STEP = DAT_WIDTH'(DAT_WIDTH / 8);

  typedef enum logic {SWEEP, READY} state_t;

  state_t               state;
  logic [ID_W-1:0]      clr_idx;
  logic                 busy_q;
  logic [DAT_WIDTH-1:0] pc_q, pc_nxt;
  logic [DAT_WIDTH-1:0] mem [REG_COUNT];
  logic                 ready, wr_arr, wr_pc;
  logic [RD_PORTS-1:0][DAT_WIDTH-1:0] rd_dat;

  assign ready  = (state == READY);
  assign wr_pc  = bus.wr_en_i && (bus.wr_id_i == PC_ID);
  assign wr_arr = ready && bus.wr_en_i && (bus.wr_id_i != '0) && (bus.wr_id_i != PC_ID);

  always_comb begin
    pc_nxt = pc_q;
    if (bus.pc_we_i)       pc_nxt = bus.pc_dat_i;
    else if (wr_pc)        pc_nxt = bus.wr_dat_i;
    else if (bus.pc_inc_i) pc_nxt = pc_q + PC_STEP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= SWEEP;
      clr_idx <= '0;
      busy_q  <= 1'b1;
      pc_q    <= PC_RESET;
    end else begin
      case (state)
        SWEEP: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_ID) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        READY: pc_q <= pc_nxt;
        default: state <= SWEEP;
      endcase
    end
  end

  // No reset on the array so it can map onto block RAM; the sweep clears it.
  always_ff @(posedge clk_i) begin
    if (!ready)      mem[clr_idx]     <= '0;
    else if (wr_arr) mem[bus.wr_id_i] <= bus.wr_dat_i;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ID_W-1:0]      id;
    logic [DAT_WIDTH-1:0] val;

    assign id = bus.rd_id_i[p*ID_W +: ID_W];

    always_comb begin
      val = mem[id];
`ifdef REGFILE_BYPASS_EN
      if (wr_arr && (id == bus.wr_id_i)) val = bus.wr_dat_i;
      if (id == PC_ID)                   val = pc_nxt;
`else
      if (id == PC_ID)                   val = pc_q;
`endif
      if (id == '0)                      val = '0;
    end

    regfile_mp_rd_port #(.DAT_WIDTH(DAT_WIDTH)) u_port (
      .clk (clk_i),
      .rst (rst_i),
      .clr (!ready),
      .en  (bus.rd_en_i[p]),
      .val (val),
      .dat (rd_dat[p])
    );
  end

  assign bus.rd_dat_o = rd_dat;
  assign bus.pc_o     = pc_q;
  assign bus.busy_o   = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table plus reset/sweep, bypass and PC sequences.
module tb_regfile_mp;
  localparam logic [63:0] PC_RST = 64'h800000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DAT_WIDTH(64), .REG_COUNT(32), .RD_PORTS(2)) bus ();

  regfile_mp #(.DAT_WIDTH(64), .REG_COUNT(32), .RD_PORTS(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_id;
    logic [63:0] wr_dat;
    logic        pc_we;
    logic [63:0] pc_dat;
    logic        pc_inc;
    logic [1:0]  rd_en;
    logic [4:0]  id0, id1;
    logic [63:0] exp0, exp1, exp_pc;
  } vec_t;

  vec_t vt [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en_i  = 1'b0;
    bus.wr_id_i  = '0;
    bus.wr_dat_i = '0;
    bus.pc_we_i  = 1'b0;
    bus.pc_dat_i = '0;
    bus.pc_inc_i = 1'b0;
    bus.rd_en_i  = '0;
    bus.rd_id_i  = '0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sweep_len(input string nm);
    int n;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (bus.busy_o == 1'b0) break;
    end
    chk(nm, 64'(n), 64'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;

    vt[0]  = '{0, 0,  0,            0, 0,     1, 2'b11, 5,  5,  0,            0,            64'h800000000008};
    vt[1]  = '{1, 3,  64'hDEADBEEF, 0, 0,     0, 2'b00, 0,  0,  0,            0,            64'h800000000008};
    vt[2]  = '{1, 4,  64'h12345678, 0, 0,     0, 2'b01, 3,  4,  64'hDEADBEEF, 0,            64'h800000000008};
    vt[3]  = '{0, 0,  0,            0, 0,     0, 2'b11, 3,  4,  64'hDEADBEEF, 64'h12345678, 64'h800000000008};
    vt[4]  = '{1, 0,  64'h1234,     0, 0,     0, 2'b11, 4,  3,  64'h12345678, 64'hDEADBEEF, 64'h800000000008};
    vt[5]  = '{0, 0,  0,            0, 0,     0, 2'b11, 0,  0,  0,            0,            64'h800000000008};
    vt[6]  = '{0, 0,  0,            0, 0,     0, 2'b10, 4,  3,  0,            64'hDEADBEEF, 64'h800000000008};
    vt[7]  = '{1, 31, 64'h200,      1, 64'h100, 1, 2'b00, 0, 0, 0,            64'hDEADBEEF, 64'h100};
    vt[8]  = '{0, 0,  0,            0, 0,     0, 2'b11, 31, 31, 64'h100,      64'h100,      64'h100};
    vt[9]  = '{1, 31, 64'h200,      0, 0,     1, 2'b11, 3,  0,  64'hDEADBEEF, 0,            64'h200};
    vt[10] = '{0, 0,  0,            0, 0,     1, 2'b11, 4,  5,  64'h12345678, 0,            64'h208};
    vt[11] = '{0, 0,  0,            1, 64'hFFFFFFFFFFFFFFF8, 0, 2'b11, 3, 4, 64'hDEADBEEF, 64'h12345678, 64'hFFFFFFFFFFFFFFF8};
    vt[12] = '{0, 0,  0,            0, 0,     1, 2'b00, 0,  0,  64'hDEADBEEF, 64'h12345678, 0};
    vt[13] = '{0, 0,  0,            0, 0,     0, 2'b11, 31, 4,  0,            64'h12345678, 0};
    vt[14] = '{1, 10, 64'h0F0F,     0, 0,     0, 2'b01, 3,  10, 64'hDEADBEEF, 64'h12345678, 0};
    vt[15] = '{0, 0,  0,            0, 0,     0, 2'b11, 10, 7,  64'h0F0F,     0,            0};

    // Reset and full sweep; writes and PC increments during the sweep must be dropped.
    idle();
    rst = 1'b1;
    tick();
    chk("rst busy", 64'(bus.busy_o), 64'd1);
    chk("rst pc", bus.pc_o, PC_RST);
    chk("rst rd0", bus.rd_dat_o[63:0], 64'd0);
    chk("rst rd1", bus.rd_dat_o[127:64], 64'd0);
    rst = 1'b0;
    bus.pc_inc_i = 1'b1;
    bus.wr_en_i  = 1'b1;
    bus.wr_id_i  = 5'd2;
    bus.wr_dat_i = 64'hAA;
    sweep_len("sweep1 len");
    idle();
    chk("sweep1 pc", bus.pc_o, PC_RST);
    bus.rd_en_i = 2'b11;
    bus.rd_id_i = {5'd2, 5'd2};
    tick();
    chk("sweep1 r2", bus.rd_dat_o[63:0], 64'd0);

    // Clear outputs back to the state the table assumes.
    bus.rd_id_i = {5'd5, 5'd5};
    tick();
    idle();

    for (int i = 0; i < 16; i++) begin
      bus.wr_en_i  = vt[i].wr_en;
      bus.wr_id_i  = vt[i].wr_id;
      bus.wr_dat_i = vt[i].wr_dat;
      bus.pc_we_i  = vt[i].pc_we;
      bus.pc_dat_i = vt[i].pc_dat;
      bus.pc_inc_i = vt[i].pc_inc;
      bus.rd_en_i  = vt[i].rd_en;
      bus.rd_id_i  = {vt[i].id1, vt[i].id0};
      tick();
      chk($sformatf("v%0d rd0", i), bus.rd_dat_o[63:0], vt[i].exp0);
      chk($sformatf("v%0d rd1", i), bus.rd_dat_o[127:64], vt[i].exp1);
      chk($sformatf("v%0d pc", i), bus.pc_o, vt[i].exp_pc);
    end
    idle();

    // Same-cycle write and read of r7.
`ifdef REGFILE_BYPASS_EN
    e = 64'h55;
`else
    e = 64'h0;
`endif
    bus.wr_en_i  = 1'b1;
    bus.wr_id_i  = 5'd7;
    bus.wr_dat_i = 64'h55;
    bus.rd_en_i  = 2'b11;
    bus.rd_id_i  = {5'd7, 5'd7};
    tick();
    chk("wr_rd r7 p0", bus.rd_dat_o[63:0], e);
    chk("wr_rd r7 p1", bus.rd_dat_o[127:64], e);
    idle();
    bus.rd_en_i = 2'b11;
    bus.rd_id_i = {5'd10, 5'd7};
    tick();
    chk("after r7", bus.rd_dat_o[63:0], 64'h55);
    chk("after r10", bus.rd_dat_o[127:64], 64'h0F0F);

    // PC read coinciding with a PC change (pc is 0 here).
    idle();
`ifdef REGFILE_BYPASS_EN
    e = 64'h8;
`else
    e = 64'h0;
`endif
    bus.pc_inc_i = 1'b1;
    bus.rd_en_i  = 2'b01;
    bus.rd_id_i  = {5'd0, 5'd31};
    tick();
    chk("pc inc rd", bus.rd_dat_o[63:0], e);
    chk("pc inc", bus.pc_o, 64'h8);
`ifdef REGFILE_BYPASS_EN
    e = 64'h40;
`else
    e = 64'h8;
`endif
    idle();
    bus.pc_we_i  = 1'b1;
    bus.pc_dat_i = 64'h40;
    bus.pc_inc_i = 1'b1;
    bus.rd_en_i  = 2'b10;
    bus.rd_id_i  = {5'd31, 5'd0};
    tick();
    chk("pc we rd", bus.rd_dat_o[127:64], e);
    chk("pc we", bus.pc_o, 64'h40);
    idle();

    // Reset from READY clears outputs; reset again at sweep cycle 10 restarts the sweep.
    rst = 1'b1;
    tick();
    chk("rst2 rd0", bus.rd_dat_o[63:0], 64'd0);
    chk("rst2 rd1", bus.rd_dat_o[127:64], 64'd0);
    chk("rst2 pc", bus.pc_o, PC_RST);
    chk("rst2 busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b0;
    bus.wr_en_i  = 1'b1;
    bus.wr_id_i  = 5'd6;
    bus.wr_dat_i = 64'h66;
    repeat (10) tick();
    chk("mid busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_len("sweep2 len");
    idle();
    bus.rd_en_i = 2'b11;
    bus.rd_id_i = {5'd3, 5'd6};
    tick();
    chk("sweep2 r6", bus.rd_dat_o[63:0], 64'd0);
    chk("sweep2 r3", bus.rd_dat_o[127:64], 64'd0);
    chk("sweep2 pc", bus.pc_o, PC_RST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
